ddr_port_arbiter: RTL

- Parametrised multi-channel front end to the DDR3 controller user interface (cmd/cmd_en/addr, wr_data/wr_data_en/wr_data_end, rd_data/rd_data_valid/rd_data_end).
- Replaces the single hard-wired memory-stage connection. Instruction fetch, memory stage and future DMA ports share one DDR3 interface.
- Supports fixed or round-robin priority and multiple outstanding reads, with in-order return routing.

---
 rtl/v850_mem_pkg.sv | 18 +
 rtl/rd_owner_fifo.sv | 53 +++++
 rtl/ddr_port_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/v850_mem_pkg.sv
// Shared types and constants for the DDR3 user-interface front end.
package v850_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2
  } arb_state_t;

  localparam logic [2:0] DDR_CMD_READ  = 3'b001;
  localparam logic [2:0] DDR_CMD_WRITE = 3'b000;

  // Width needed to hold a channel index; a single channel still needs one bit.
  function automatic int owner_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rd_owner_fifo.sv
// Records which channel issued each outstanding read so returns can be
// routed back in issue order.
module rd_owner_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_MAX = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Pointer and occupancy update; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Multi-channel front end sharing one DDR3 controller user interface.
//
// state | meaning
// IDLE  | waiting for calibration and an eligible request; grant shown on ready
// CMD   | cmd_en held with latched cmd/addr until the controller accepts it
// WDATA | write beat held with data/mask/end until the controller accepts it
module ddr_port_arbiter
  import v850_mem_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 29,
  parameter int DATA_W   = 256,
  parameter int MASK_W   = 32,
  parameter int RR_MODE  = 1,
  parameter int RD_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     calib_done_i,
  input  logic [NUM_CH-1:0]        ch_req_valid_i,
  output logic [NUM_CH-1:0]        ch_req_ready_o,
  input  logic [NUM_CH-1:0]        ch_req_write_i,
  input  logic [NUM_CH*ADDR_W-1:0] ch_req_addr_i,
  input  logic [NUM_CH*DATA_W-1:0] ch_wr_data_i,
  input  logic [NUM_CH*MASK_W-1:0] ch_wr_mask_i,
  output logic [NUM_CH-1:0]        ch_rd_valid_o,
  output logic [DATA_W-1:0]        ch_rd_data_o,
  input  logic                     ddr_cmd_rdy_i,
  output logic                     ddr_en_o,
  output logic [2:0]               ddr_cmd_o,
  output logic [ADDR_W-1:0]        ddr_addr_o,
  input  logic                     ddr_write_rdy_i,
  output logic                     ddr_write_en_o,
  output logic [DATA_W-1:0]        ddr_write_data_o,
  output logic [MASK_W-1:0]        ddr_write_mask_o,
  output logic                     ddr_write_data_end_o,
  input  logic [DATA_W-1:0]        ddr_read_data_i,
  input  logic                     ddr_read_data_valid_i,
  input  logic                     ddr_read_data_end_i,
  output logic                     rd_err_o
);

  localparam int OW = owner_w(NUM_CH);

  arb_state_t          state;
  logic                hold_write;
  logic [OW-1:0]       hold_owner;
  logic [OW-1:0]       rr_ptr;
  logic [NUM_CH-1:0]   elig;
  logic                grant_any;
  logic                grant_ok;
  logic [OW-1:0]       gnt_idx;
  logic [OW-1:0]       gnt_next;
  logic                sel_write;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic [MASK_W-1:0]   sel_mask;
  logic                fifo_full;
  logic                fifo_empty;
  logic [OW-1:0]       fifo_head;
  logic                fifo_push;
  logic                fifo_pop;
  logic                rd_ret;

  // A read may only be granted while the owner FIFO has room for it.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      elig[i] = ch_req_valid_i[i] & (ch_req_write_i[i] | ~fifo_full);
  end

  // Search eligible channels from the rotating start (or from 0 in fixed mode).
  always_comb begin
    grant_any = 1'b0;
    gnt_idx   = '0;
    gnt_next  = '0;
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    sel_mask  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!grant_any && elig[i] &&
            i == ((RR_MODE != 0) ? ((int'(rr_ptr) + k) % NUM_CH) : k)) begin
          grant_any = 1'b1;
          gnt_idx   = OW'(i);
          gnt_next  = OW'((i + 1) % NUM_CH);
          sel_write = ch_req_write_i[i];
          sel_addr  = ch_req_addr_i[i*ADDR_W +: ADDR_W];
          sel_data  = ch_wr_data_i[i*DATA_W +: DATA_W];
          sel_mask  = ch_wr_mask_i[i*MASK_W +: MASK_W];
        end
      end
    end
  end

  assign grant_ok = (state == IDLE) & calib_done_i & grant_any;

  // One-hot accept toward the winning channel, forced quiet during reset.
  always_comb begin
    ch_req_ready_o = '0;
    if (grant_ok && !rst)
      for (int i = 0; i < NUM_CH; i++)
        if (gnt_idx == OW'(i)) ch_req_ready_o[i] = 1'b1;
  end

  // Command/write sequencing; the output registers double as the holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      hold_write       <= 1'b0;
      hold_owner       <= '0;
      rr_ptr           <= '0;
      ddr_en_o         <= 1'b0;
      ddr_cmd_o        <= '0;
      ddr_addr_o       <= '0;
      ddr_write_en_o   <= 1'b0;
      ddr_write_data_o <= '0;
      ddr_write_mask_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_ok) begin
            hold_write       <= sel_write;
            hold_owner       <= gnt_idx;
            rr_ptr           <= gnt_next;
            ddr_en_o         <= 1'b1;
            ddr_cmd_o        <= sel_write ? DDR_CMD_WRITE : DDR_CMD_READ;
            ddr_addr_o       <= sel_addr;
            ddr_write_data_o <= sel_data;
            ddr_write_mask_o <= sel_mask;
            state            <= CMD;
          end
        end
        CMD: begin
          if (ddr_cmd_rdy_i) begin
            ddr_en_o <= 1'b0;
            if (hold_write) begin
              ddr_write_en_o <= 1'b1;
              state          <= WDATA;
            end else begin
              state <= IDLE;
            end
          end
        end
        WDATA: begin
          if (ddr_write_rdy_i) begin
            ddr_write_en_o <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ddr_write_data_end_o = ddr_write_en_o;

  assign rd_ret    = ddr_read_data_valid_i & ddr_read_data_end_i;
  assign fifo_push = (state == CMD) & ddr_cmd_rdy_i & ~hold_write;
  assign fifo_pop  = rd_ret & ~fifo_empty;

  rd_owner_fifo #(
    .DEPTH (RD_DEPTH),
    .W     (OW)
  ) u_owner_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (hold_owner),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Zero-latency return strobe to the owner at the FIFO head.
  always_comb begin
    ch_rd_valid_o = '0;
    if (fifo_pop && !rst)
      for (int i = 0; i < NUM_CH; i++)
        if (fifo_head == OW'(i)) ch_rd_valid_o[i] = 1'b1;
  end

  assign ch_rd_data_o = rst ? '0 : ddr_read_data_i;

  // Sticky flag for read data arriving with nothing outstanding.
  always_ff @(posedge clk) begin
    if (rst)                      rd_err_o <= 1'b0;
    else if (rd_ret && fifo_empty) rd_err_o <= 1'b1;
  end

endmodule
